// File: rtl/sym_game_sequencer.sv
// Round sequencer for the symbol-counting game: countdown, period, answer window, scoring, result.
// Every output is registered; symGenMax shrinks after each correct round down to a floor.
module sym_game_sequencer #(
  parameter int unsigned COUNTDOWN_SECS = 3,
  parameter int unsigned PERIOD_SECS    = 15,
  parameter int unsigned ANSWER_SECS    = 10,
  parameter int unsigned RESULT_SECS    = 2,
  parameter int unsigned NUM_ROUNDS     = 5,
  parameter logic [31:0] BASE_GEN_MAX   = 32'd100_000_000,
  parameter logic [31:0] GEN_MAX_STEP   = 32'd10_000_000,
  parameter logic [31:0] MIN_GEN_MAX    = 32'd20_000_000
) (
  input  logic        Clk100M,
  input  logic        Reset,
  input  logic        tick1Hz,
  input  logic        startBtn,
  input  logic        submitBtn,
  input  logic [7:0]  answerIn,
  input  logic        periodDone,
  input  logic [7:0]  numSpecial,
  output logic        gameSig,
  output logic        answerSig,
  output logic [31:0] symGenMax,
  output logic [3:0]  round,
  output logic [7:0]  score,
  output logic [7:0]  expected,
  output logic        correct,
  output logic        resultValid,
  output logic        gameOver,
  output logic        errFlag,
  output logic [7:0]  secLeft,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_ANSWER    = 3'd3,
    S_RESULT    = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t      cur_state, nxt_state;
  logic [3:0]  nxt_round;
  logic [7:0]  nxt_score, nxt_expected, nxt_sec;
  logic [31:0] nxt_gen_max;
  logic        nxt_correct, nxt_game;
  logic        tick_last, answer_match;
  logic [7:0]  sec_dec;
  logic [32:0] gen_diff;
  logic [31:0] gen_next;

  assign state = cur_state;

  // A tick on the final second ends a timed state; otherwise it just counts down.
  assign tick_last    = tick1Hz && (secLeft == 8'd1);
  assign sec_dec      = (tick1Hz && secLeft != 8'd0) ? secLeft - 8'd1 : secLeft;
  assign answer_match = (answerIn == expected);

  // 33-bit subtraction so a step larger than the current value clamps to the floor.
  assign gen_diff = {1'b0, symGenMax} - {1'b0, GEN_MAX_STEP};
  assign gen_next = (gen_diff[32] || gen_diff[31:0] < MIN_GEN_MAX) ? MIN_GEN_MAX : gen_diff[31:0];

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      cur_state   <= S_IDLE;
      round       <= 4'd0;
      score       <= 8'd0;
      expected    <= 8'd0;
      secLeft     <= 8'd0;
      symGenMax   <= BASE_GEN_MAX;
      correct     <= 1'b0;
      gameSig     <= 1'b0;
      answerSig   <= 1'b0;
      resultValid <= 1'b0;
      gameOver    <= 1'b0;
      errFlag     <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      round       <= nxt_round;
      score       <= nxt_score;
      expected    <= nxt_expected;
      secLeft     <= nxt_sec;
      symGenMax   <= nxt_gen_max;
      correct     <= nxt_correct;
      gameSig     <= nxt_game;
      answerSig   <= (nxt_state == S_ANSWER);
      resultValid <= (nxt_state == S_RESULT);
      gameOver    <= (nxt_state == S_DONE);
      errFlag     <= (nxt_state == S_ERROR);
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    nxt_round    = round;
    nxt_score    = score;
    nxt_expected = expected;
    nxt_sec      = sec_dec;
    nxt_gen_max  = symGenMax;
    nxt_correct  = correct;
    nxt_game     = 1'b0;

    case (cur_state)
      S_IDLE, S_DONE, S_ERROR: begin
        nxt_sec = 8'd0;
        if (startBtn) begin
          nxt_state   = S_COUNTDOWN;
          nxt_round   = 4'd0;
          nxt_score   = 8'd0;
          nxt_correct = 1'b0;
          nxt_gen_max = BASE_GEN_MAX;
          nxt_sec     = 8'(COUNTDOWN_SECS);
        end
      end
      S_COUNTDOWN: begin
        if (tick_last) begin
          nxt_state = S_RUN;
          nxt_sec   = 8'(PERIOD_SECS + 2);
          nxt_game  = 1'b1;
        end
      end
      S_RUN: begin
        if (periodDone) begin
          nxt_state    = S_ANSWER;
          nxt_expected = numSpecial;
          nxt_sec      = 8'(ANSWER_SECS);
        end else if (tick_last) begin
          nxt_state = S_ERROR;
          nxt_sec   = 8'd0;
        end
      end
      S_ANSWER: begin
        if (submitBtn) begin
          nxt_state   = S_RESULT;
          nxt_correct = answer_match;
          if (answer_match && score != 8'hFF)
            nxt_score = score + 8'd1;
          nxt_sec = 8'(RESULT_SECS);
        end else if (tick_last) begin
          nxt_state   = S_RESULT;
          nxt_correct = 1'b0;
          nxt_sec     = 8'(RESULT_SECS);
        end
      end
      S_RESULT: begin
        if (tick_last) begin
          if (round == 4'(NUM_ROUNDS - 1)) begin
            nxt_state = S_DONE;
            nxt_sec   = 8'd0;
          end else begin
            nxt_state = S_COUNTDOWN;
            nxt_round = round + 4'd1;
            nxt_sec   = 8'(COUNTDOWN_SECS);
            if (correct)
              nxt_gen_max = gen_next;
          end
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_sec   = 8'd0;
      end
    endcase
  end

endmodule
